wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback
//  (ResultW/RDW/RegWriteW) and a long-latency unit (LU, e.g. mul/div).
//  LU results are queued in a small FIFO and drained into idle write-port cycles.
//  A starvation counter forces a drain by stalling the pipeline's W stage.

---
 rtl/wb_port_arbiter.sv | 119 +++++++++++
 tb/tb_wb_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results
// wait in a small FIFO and drain into idle cycles or through a forced one-cycle W stall.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWriteW,
  input  logic [AW-1:0]            RDW,
  input  logic [DW-1:0]            ResultW,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [AW-1:0]            lu_rd,
  input  logic [DW-1:0]            lu_data,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_rd,
  output logic [DW-1:0]            rf_wd,
  output logic                     StallW,
  output logic [$clog2(DEPTH):0]   lu_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic          sq;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  typedef enum logic {NORMAL, DRAIN} st_t;

  ent_t            fifo [DEPTH];
  logic [PW-1:0]   rptr, wptr;
  st_t             state;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic [CNTW-1:0] cnt_nxt;
  logic            full, nempty, pipe_req, pipe_gnt, pop, push, head_live;
  ent_t            head;

  assign full      = (lu_count == CNTW'(DEPTH));
  assign nempty    = (lu_count != '0);
  assign pipe_req  = RegWriteW & (RDW != '0);
  assign pipe_gnt  = (state == NORMAL) & pipe_req;
  assign head      = fifo[rptr];
  assign pop       = nempty & ((state == DRAIN) | ~pipe_req);
  assign head_live = pop & ~head.sq;
  // ready only looks at registered occupancy, so a same-cycle pop never frees a slot early
  assign lu_ready  = rst & ~full;
  assign push      = lu_valid & lu_ready & (lu_rd != '0);
  assign cnt_nxt   = lu_count + CNTW'(push) - CNTW'(pop);

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (rst) begin
      if (pipe_gnt) begin
        rf_we = 1'b1;
        rf_rd = RDW;
        rf_wd = ResultW;
      end else if (head_live) begin
        rf_we = 1'b1;
        rf_rd = head.rd;
        rf_wd = head.data;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (state == DRAIN)
      starve_nxt = '0;
    else if (pipe_req) begin
      if (nempty && starve_cnt < SW'(STARVE_MAX))
        starve_nxt = starve_cnt + SW'(1);
    end else
      starve_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= NORMAL;
      StallW     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (state == NORMAL && starve_nxt == SW'(STARVE_MAX) && cnt_nxt != '0) begin
        state  <= DRAIN;
        StallW <= 1'b1;
      end else begin
        state  <= NORMAL;
        StallW <= 1'b0;
      end
    end
  end

  // A pipeline grant is younger than anything buffered, so matching entries must never land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr     <= '0;
      wptr     <= '0;
      lu_count <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      lu_count <= cnt_nxt;
      if (pop)  rptr <= rptr + PW'(1);
      if (push) wptr <= wptr + PW'(1);
      for (int i = 0; i < DEPTH; i++)
        if (pipe_gnt && fifo[i].rd == RDW) fifo[i].sq <= 1'b1;
      if (push) fifo[wptr] <= '{sq: pipe_gnt && (lu_rd == RDW), rd: lu_rd, data: lu_data};
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, idle drain, forced drain, WAW squash,
// FIFO backpressure, x0 writes and reset during a stall.
module tb_wb_port_arbiter;
  localparam int AW = 5, DW = 32, DEPTH = 2;

  logic          clk = 1'b0, rst = 1'b0;
  logic          RegWriteW, lu_valid, lu_ready, rf_we, StallW;
  logic [AW-1:0] RDW, lu_rd, rf_rd;
  logic [DW-1:0] ResultW, lu_data, rf_wd;
  logic [1:0]    lu_count;
  logic [DW-1:0] shadow [32];
  int            npass = 0, ntot = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .StallW(StallW), .lu_count(lu_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) shadow[rf_rd] <= rf_wd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drv(input logic rw, input logic [AW-1:0] rd, input logic [DW-1:0] res,
                     input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    RegWriteW = rw; RDW = rd; ResultW = res;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic wr(input string tag, input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    chk({tag, "_we"}, rf_we, we);
    if (we) begin
      chk({tag, "_rd"}, rf_rd, rd);
      chk({tag, "_wd"}, rf_wd, wd);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    // 1: reset with LU offering a result
    drv(1, 3, 32'h33, 1, 4, 32'h44);
    chk("rst_ready", lu_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_stall", StallW, 0);
    chk("rst_cnt", lu_count, 0);
    nxt(); rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    chk("rel_ready", lu_ready, 1);
    chk("rel_cnt", lu_count, 0);
    nxt();

    // 2: idle pipeline, LU result lands the cycle after its push
    drv(0, 0, 0, 1, 5, 32'hDEADBEEF);
    wr("t2_nobypass", 0, 0, 0);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    wr("t2_drain", 1, 5, 32'hDEADBEEF);
    chk("t2_cnt1", lu_count, 1);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    chk("t2_cnt0", lu_count, 0);
    wr("t2_idle", 0, 0, 0);
    nxt();

    // 3: pipeline busy every cycle forces a one-cycle drain
    drv(1, 1, 32'h101, 1, 9, 32'h99);
    wr("t3_a", 1, 1, 32'h101);
    nxt();
    for (int k = 0; k < 4; k++) begin
      drv(1, AW'(2 + k), DW'(32'h102 + k), 0, 0, 0);
      wr("t3_b", 1, AW'(2 + k), DW'(32'h102 + k));
      chk("t3_b_stall", StallW, 0);
      chk("t3_b_cnt", lu_count, 1);
      nxt();
    end
    drv(1, 6, 32'h106, 0, 0, 0);
    chk("t3_d_stall", StallW, 1);
    wr("t3_d", 1, 9, 32'h99);
    nxt();
    drv(1, 6, 32'h106, 0, 0, 0);
    chk("t3_e_stall", StallW, 0);
    wr("t3_e", 1, 6, 32'h106);
    chk("t3_e_cnt", lu_count, 0);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    wr("t3_f", 0, 0, 0);
    chk("t3_x6", shadow[6], 32'h106);
    chk("t3_x9", shadow[9], 32'h99);
    nxt();

    // 4: younger pipeline write squashes a buffered LU result to the same register
    drv(0, 0, 0, 1, 7, 32'h77);
    wr("t4_push", 0, 0, 0);
    nxt();
    drv(1, 7, 32'h11, 0, 0, 0);
    wr("t4_pipe", 1, 7, 32'h11);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    wr("t4_sqpop", 0, 0, 0);
    chk("t4_cnt1", lu_count, 1);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    chk("t4_cnt0", lu_count, 0);
    wr("t4_after", 0, 0, 0);
    chk("t4_x7", shadow[7], 32'h11);
    nxt();

    // 5: three LU results into a two-entry FIFO behind a busy pipeline
    drv(1, 20, 32'h200, 1, 11, 32'hB1);
    chk("t5_p1_ready", lu_ready, 1);
    wr("t5_p1", 1, 20, 32'h200);
    nxt();
    drv(1, 21, 32'h201, 1, 12, 32'hB2);
    chk("t5_p2_ready", lu_ready, 1);
    nxt();
    drv(1, 22, 32'h202, 1, 13, 32'hB3);
    chk("t5_p3_ready", lu_ready, 0);
    chk("t5_p3_cnt", lu_count, 2);
    wr("t5_p3", 1, 22, 32'h202);
    nxt();
    drv(1, 23, 32'h203, 1, 13, 32'hB3);
    chk("t5_p4_ready", lu_ready, 0);
    nxt();
    drv(0, 0, 0, 1, 13, 32'hB3);
    chk("t5_p5_ready", lu_ready, 0);
    wr("t5_p5", 1, 11, 32'hB1);
    nxt();
    drv(0, 0, 0, 1, 13, 32'hB3);
    chk("t5_p6_ready", lu_ready, 1);
    wr("t5_p6", 1, 12, 32'hB2);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    wr("t5_p7", 1, 13, 32'hB3);
    chk("t5_p7_cnt", lu_count, 1);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    chk("t5_p8_cnt", lu_count, 0);
    wr("t5_p8", 0, 0, 0);
    chk("t5_stall", StallW, 0);
    nxt();

    // 6: writes to x0 from either source are dropped
    drv(1, 0, 32'h55, 1, 0, 32'h66);
    wr("t6_x0", 0, 0, 0);
    chk("t6_ready", lu_ready, 1);
    nxt();
    drv(0, 0, 0, 0, 0, 0);
    chk("t6_cnt", lu_count, 0);
    wr("t6_after", 0, 0, 0);
    nxt();

    // reset arriving while the W stage is stalled
    drv(1, 1, 32'h1, 1, 3, 32'h3);
    nxt();
    for (int k = 0; k < 4; k++) begin
      drv(1, 1, 32'h1, 0, 0, 0);
      nxt();
    end
    drv(1, 1, 32'h1, 0, 0, 0);
    chk("rd_stall_pre", StallW, 1);
    rst = 1'b0;
    #1;
    chk("rd_stall", StallW, 0);
    chk("rd_cnt", lu_count, 0);
    chk("rd_we", rf_we, 0);
    chk("rd_ready", lu_ready, 0);
    nxt(); rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    chk("rd_rel_ready", lu_ready, 1);
    chk("rd_rel_stall", StallW, 0);
    chk("rd_rel_we", rf_we, 0);
    nxt();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
